// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: streams a latched word MSB-first through a short history
// register and counts (overlapping) occurrences of a right-aligned target pattern.
module pattern_scan_ctrl #(
  parameter int W    = 16,
  parameter int MAXP = 5
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    data_in,
  input  logic [MAXP-1:0] pattern,
  input  logic [2:0]      pat_len,
  output logic            busy,
  output logic            done,
  output logic            bit_out,
  output logic            bit_valid,
  output logic            match,
  output logic [4:0]      match_count,
  output logic [4:0]      first_pos
);

  localparam int         IW      = $clog2(W);
  localparam logic [2:0] LEN_MAX = 3'(MAXP);
  localparam logic [4:0] NO_POS  = 5'h1F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    word_reg;
  logic [MAXP-1:0] pat_reg;
  logic [MAXP-1:0] hist_reg;
  logic [2:0]      len_reg;
  logic [2:0]      fill_reg;
  logic [IW-1:0]   idx_reg;

  logic [2:0]      len_clamped;
  logic [MAXP-1:0] len_mask;
  logic [MAXP-1:0] hist_next;
  logic [2:0]      fill_next;
  logic [IW-1:0]   idx_dec;
  logic            hit;

  always_comb begin
    len_clamped = pat_len;
    if (pat_len == 3'd0)
      len_clamped = 3'd1;
    else if (pat_len > LEN_MAX)
      len_clamped = LEN_MAX;
  end

  // Only the low len_reg bits of history/pattern take part in the compare.
  generate
    for (genvar gi = 0; gi < MAXP; gi++) begin : g_mask
      assign len_mask[gi] = (3'(gi) < len_reg);
    end
  endgenerate

  assign hist_next = {hist_reg[MAXP-2:0], bit_out};
  assign fill_next = (fill_reg >= LEN_MAX) ? LEN_MAX : fill_reg + 3'd1;
  assign idx_dec   = idx_reg - IW'(1);
  assign hit       = (fill_next >= len_reg) && (((hist_next ^ pat_reg) & len_mask) == '0);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      word_reg    <= '0;
      pat_reg     <= '0;
      hist_reg    <= '0;
      len_reg     <= 3'd1;
      fill_reg    <= '0;
      idx_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      match       <= 1'b0;
      match_count <= '0;
      first_pos   <= NO_POS;
    end else begin
      match <= 1'b0;
      done  <= 1'b0;
      case (state_reg)
        IDLE: begin
          busy      <= 1'b0;
          bit_valid <= 1'b0;
          bit_out   <= 1'b0;
          if (start) begin
            word_reg    <= data_in;
            pat_reg     <= pattern;
            len_reg     <= len_clamped;
            hist_reg    <= '0;
            fill_reg    <= '0;
            idx_reg     <= IW'(W - 1);
            match_count <= '0;
            first_pos   <= NO_POS;
            busy        <= 1'b1;
            bit_valid   <= 1'b1;
            bit_out     <= data_in[W-1];
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          hist_reg <= hist_next;
          fill_reg <= fill_next;
          idx_reg  <= idx_dec;
          if (hit) begin
            match       <= 1'b1;
            match_count <= match_count + 5'd1;
            if (first_pos == NO_POS)
              first_pos <= 5'(IW'(W - 1) - idx_reg);
          end
          // bit_out is registered, so the next stream bit is fetched one index ahead.
          if (idx_reg == '0) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
            done      <= 1'b1;
          end else begin
            bit_out <= word_reg[idx_dec];
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          bit_valid <= 1'b0;
          bit_out   <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          bit_valid <= 1'b0;
          bit_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed and random scans of pattern_scan_ctrl checked cycle by cycle against a
// reference that finds pattern occurrences directly in the word.
module tb_pattern_scan_ctrl;

  logic        CLK = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic [4:0]  pattern;
  logic [2:0]  pat_len;
  logic        busy;
  logic        done;
  logic        bit_out;
  logic        bit_valid;
  logic        match;
  logic [4:0]  match_count;
  logic [4:0]  first_pos;

  int checks  = 0;
  int errors  = 0;
  int scan_id = 0;

  always #5 CLK = ~CLK;

  pattern_scan_ctrl #(.W(16), .MAXP(5)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .busy        (busy),
    .done        (done),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .match       (match),
    .match_count (match_count),
    .first_pos   (first_pos)
  );

  initial begin
    #500000;
    $display("FAIL watchdog scan=%0d observed timeout expected finish", scan_id);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s scan=%0d observed %0h expected %0h", tag, scan_id, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_bit_out"}, 32'(bit_out), 32'd0);
    chk({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
    chk({tag, "_match"}, 32'(match), 32'd0);
    chk({tag, "_count"}, 32'(match_count), 32'd0);
    chk({tag, "_first"}, 32'(first_pos), 32'h1F);
  endtask

  // restart_cyc: cycle in which a stray start is raised (0 = none).
  // rst_cyc: cycle in which rst is pulsed mid-cycle (0 = none).
  task automatic run_scan(input logic [15:0] w, input logic [4:0] p, input logic [2:0] l,
                          input int restart_cyc, input int rst_cyc);
    int   eff;
    bit   mpos[16];
    bit   ok;
    int   cnt;
    int   first;
    logic exp_bit;
    bit   exp_match;

    scan_id++;
    eff = (l == 3'd0) ? 1 : (l > 3'd5) ? 5 : int'(l);
    for (int pos = 0; pos < 16; pos++) begin
      mpos[pos] = 1'b0;
      if (pos + 1 >= eff) begin
        ok = 1'b1;
        for (int k = 0; k < eff; k++)
          if (w[15 - (pos - k)] != p[k]) ok = 1'b0;
        mpos[pos] = ok;
      end
    end

    @(negedge CLK);
    data_in = w;
    pattern = p;
    pat_len = l;
    start   = 1'b1;
    @(posedge CLK);
    #1;
    start   = 1'b0;
    data_in = 16'($urandom);
    pattern = 5'($urandom);
    pat_len = 3'($urandom);

    cnt   = 0;
    first = 31;
    for (int c = 1; c <= 19; c++) begin
      @(negedge CLK);
      if (c == rst_cyc) begin
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        @(negedge CLK);
        chk_reset_vals("rst_held");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge CLK);
          chk("post_rst_done", 32'(done), 32'd0);
          chk("post_rst_busy", 32'(busy), 32'd0);
        end
        $display("scan %0d word=%h pat=%b len=%0d aborted by rst in cycle %0d", scan_id, w, p, l, c);
        return;
      end
      // A match completed by position q is pulsed in cycle q+2.
      exp_match = (c >= 2 && c <= 17) ? mpos[c - 2] : 1'b0;
      if (exp_match) begin
        cnt++;
        if (first == 31) first = c - 2;
      end
      exp_bit = (c <= 16) ? w[16 - c] : 1'b0;
      chk("busy", 32'(busy), (c <= 16) ? 32'd1 : 32'd0);
      chk("bit_valid", 32'(bit_valid), (c <= 16) ? 32'd1 : 32'd0);
      chk("bit_out", 32'(bit_out), 32'(exp_bit));
      chk("done", 32'(done), (c == 17) ? 32'd1 : 32'd0);
      chk("match", 32'(match), 32'(exp_match));
      chk("match_count", 32'(match_count), 32'(cnt));
      chk("first_pos", 32'(first_pos), 32'(first));
      if (c == restart_cyc) begin
        start   = 1'b1;
        data_in = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
    end
    $display("scan %0d word=%h pat=%b len=%0d matches=%0d first=%0d dut_count=%0d dut_first=%0d",
             scan_id, w, p, l, cnt, first, match_count, first_pos);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    pattern = '0;
    pat_len = '0;
    #2 chk_reset_vals("reset_hold");
    @(negedge CLK);
    @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    chk_reset_vals("idle_after_rst");

    run_scan(16'b1011_0000_0101_1000, 5'b10110, 3'd5, 0, 0);
    chk("r031_count", 32'(match_count), 32'd2);
    chk("r031_first", 32'(first_pos), 32'd4);

    run_scan(16'hAAAA, 5'b00101, 3'd3, 0, 0);
    chk("r032_count", 32'(match_count), 32'd7);
    chk("r032_first", 32'(first_pos), 32'd2);

    run_scan(16'hFFFF, 5'b00001, 3'd1, 0, 0);
    chk("r033_count", 32'(match_count), 32'd16);
    chk("r033_first", 32'(first_pos), 32'd0);

    run_scan(16'hFFFF, 5'b00001, 3'd0, 0, 0);
    chk("r033_len0_count", 32'(match_count), 32'd16);
    chk("r033_len0_first", 32'(first_pos), 32'd0);

    run_scan(16'h0000, 5'b10110, 3'd5, 0, 0);
    chk("r034_count", 32'(match_count), 32'd0);
    chk("r034_first", 32'(first_pos), 32'h1F);

    run_scan(16'b1011_0000_0101_1000, 5'b10110, 3'd5, 5, 0);
    chk("r035_count", 32'(match_count), 32'd2);
    chk("r035_first", 32'(first_pos), 32'd4);

    run_scan(16'b1011_0000_0101_1000, 5'b10110, 3'd5, 0, 8);
    run_scan(16'b1011_0000_0101_1000, 5'b10110, 3'd5, 0, 0);
    chk("r036_count", 32'(match_count), 32'd2);
    chk("r036_first", 32'(first_pos), 32'd4);

    for (int n = 0; n < 30; n++) begin
      logic [15:0] rw;
      rw = 16'($urandom);
      if (n % 3 == 0) rw = {4{rw[3:0]}};
      run_scan(rw, 5'($urandom), 3'($urandom_range(0, 7)), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
